// File: rtl/approx_add_err_monitor.sv
// Windowed error monitor for an approximate adder: compares the adder's sum
// against the exact sum and reports error count, max and summed distance.
module approx_add_err_monitor #(
    parameter int unsigned WIDTH       = 15,
    parameter int unsigned WINDOW_LOG2 = 8,
    parameter int unsigned ACC_W       = WIDTH + 1 + WINDOW_LOG2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [WIDTH:0]         in_approx,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ack,
    output logic [WINDOW_LOG2:0]   err_count,
    output logic [WIDTH:0]         err_max,
    output logic [ACC_W-1:0]       err_sum
);

    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned CW = WINDOW_LOG2 + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((2 ** WINDOW_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   sample_cnt;
    logic            s1_valid;
    logic [SW-1:0]   s1_exact;
    logic [SW-1:0]   s1_approx;
    logic            s2_valid;
    logic [SW-1:0]   s2_ed;
    logic            accept_c;
    logic            clear_c;
    logic [SW-1:0]   ed_c;

    assign accept_c = in_valid & in_ready;
    // start only opens a window from IDLE or DONE; ignored while measuring
    assign clear_c  = start & ((state == IDLE) | (state == DONE));
    assign ed_c     = (s1_exact >= s1_approx) ? (s1_exact - s1_approx)
                                              : (s1_approx - s1_exact);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start has priority over res_ack in DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = RUN;
            RUN:   if (accept_c && (sample_cnt == LAST_CNT)) next_state = DRAIN;
            DRAIN: if (!s1_valid && !s2_valid) next_state = DONE;
            DONE: begin
                if (start) begin
                    next_state = RUN;
                end else if (res_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered status outputs, aligned with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            in_ready  <= (next_state == RUN);
            busy      <= (next_state == RUN) || (next_state == DRAIN);
            res_valid <= (next_state == DONE);
        end
    end

    // Accepted-sample counter for the current window
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (clear_c) begin
            sample_cnt <= '0;
        end else if (accept_c) begin
            sample_cnt <= sample_cnt + CW'(1);
        end
    end

    // Stage 1: exact sum; stage 2: absolute error distance
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
            s2_valid  <= 1'b0;
            s2_ed     <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_exact  <= SW'(in_a) + SW'(in_b);
                s1_approx <= in_approx;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ed <= ed_c;
            end
        end
    end

    // Error accumulators, cleared when a window opens
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            err_max   <= '0;
            err_sum   <= '0;
        end else if (clear_c) begin
            err_count <= '0;
            err_max   <= '0;
            err_sum   <= '0;
        end else if (s2_valid) begin
            err_sum <= err_sum + ACC_W'(s2_ed);
            if (s2_ed > err_max) begin
                err_max <= s2_ed;
            end
            if (s2_ed != '0) begin
                err_count <= err_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Bench for approx_add_err_monitor: a 256-sample instance and a 4-sample
// instance share clock and reset; window results are checked by monitors
// against expectations queued by the stimulus.
module tb_approx_add_err_monitor;

    typedef struct {
        longint cnt;
        longint mx;
        longint sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 256-sample instance
    logic        start8 = 0, in_valid8 = 0, res_ack8 = 0;
    logic        in_ready8, busy8, res_valid8;
    logic [14:0] in_a8 = '0, in_b8 = '0;
    logic [15:0] in_approx8 = '0;
    logic [8:0]  err_count8;
    logic [15:0] err_max8;
    logic [23:0] err_sum8;

    // 4-sample instance
    logic        start2 = 0, in_valid2 = 0, res_ack2 = 0;
    logic        in_ready2, busy2, res_valid2;
    logic [14:0] in_a2 = '0, in_b2 = '0;
    logic [15:0] in_approx2 = '0;
    logic [2:0]  err_count2;
    logic [15:0] err_max2;
    logic [17:0] err_sum2;

    int passed = 0;
    int total  = 0;

    exp_t q8[$];
    exp_t q2[$];

    // Valid pattern 1,0,1,1,0,1; valid slots carry eds 4,0,9,1, idle slots carry junk
    int          w2_v  [6] = '{1, 0, 1, 1, 0, 1};
    logic [14:0] w2_a  [6] = '{15'd10, 15'h7FFF, 15'd5, 15'd20, 15'h7FFF, 15'd100};
    logic [14:0] w2_b  [6] = '{15'd0,  15'h7FFF, 15'd5, 15'd1,  15'h7FFF, 15'd0};
    logic [15:0] w2_ap [6] = '{16'd14, 16'd0,    16'd10, 16'd12, 16'd0,   16'd101};

    approx_add_err_monitor #(.WIDTH(15), .WINDOW_LOG2(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid8),
        .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8), .in_approx(in_approx8),
        .busy(busy8), .res_valid(res_valid8), .res_ack(res_ack8),
        .err_count(err_count8), .err_max(err_max8), .err_sum(err_sum8)
    );

    approx_add_err_monitor #(.WIDTH(15), .WINDOW_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2),
        .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2), .in_approx(in_approx2),
        .busy(busy2), .res_valid(res_valid2), .res_ack(res_ack2),
        .err_count(err_count2), .err_max(err_max2), .err_sum(err_sum2)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Result monitors: compare on each rising res_valid
    logic prev8 = 1'b0;
    logic prev2 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (res_valid8 && !prev8) begin
            if (q8.size() == 0) begin
                check("unexpected_res8", 1, 0);
            end else begin
                e = q8.pop_front();
                check("res8_count", longint'(err_count8), e.cnt);
                check("res8_max",   longint'(err_max8),   e.mx);
                check("res8_sum",   longint'(err_sum8),   e.sum);
            end
        end
        if (res_valid2 && !prev2) begin
            if (q2.size() == 0) begin
                check("unexpected_res2", 1, 0);
            end else begin
                e = q2.pop_front();
                check("res2_count", longint'(err_count2), e.cnt);
                check("res2_max",   longint'(err_max2),   e.mx);
                check("res2_sum",   longint'(err_sum2),   e.sum);
            end
        end
        prev8 = res_valid8;
        prev2 = res_valid2;
    end

    // Offer one sample to the 256-sample instance and wait for its accept edge
    task automatic send8(input logic [14:0] a, input logic [14:0] b, input logic [15:0] ap);
        int guard = 0;
        in_valid8  = 1'b1;
        in_a8      = a;
        in_b8      = b;
        in_approx8 = ap;
        while (!in_ready8 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check("send8_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    // One full window: kind 0 constant error, 1 exact sums, 2 worst case
    task automatic run8(input int kind, input longint exp_cnt);
        logic [14:0] a, b;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("start8_clear_sum", longint'(err_sum8), 0);
        check("start8_in_ready", longint'(in_ready8), 1);
        for (int i = 0; i < 256; i++) begin
            case (kind)
                0: send8(15'd0, 15'd0, 16'h00FF);
                1: begin
                    a = 15'($urandom_range(0, 32767));
                    b = 15'($urandom_range(0, 32767));
                    send8(a, b, 16'(a) + 16'(b));
                end
                default: send8(15'h7FFF, 15'h7FFF, 16'd0);
            endcase
        end
        check("drain8_in_ready", longint'(in_ready8), 0);
        check("drain8_busy", longint'(busy8), 1);
        @(posedge clk); #1;
        check("drain8_res_valid_p1", longint'(res_valid8), 0);
        @(posedge clk); #1;
        check("drain8_res_valid_p2", longint'(res_valid8), 0);
        check("acc8_at_p2", longint'(err_count8), exp_cnt);
        @(posedge clk); #1;
        check("res_valid8_latency", longint'(res_valid8), 1);
        check("done8_busy", longint'(busy8), 0);
    endtask

    task automatic ack8(input longint exp_cnt);
        res_ack8 = 1'b1;
        @(posedge clk); #1;
        res_ack8 = 1'b0;
        check("ack8_res_valid", longint'(res_valid8), 0);
        check("ack8_kept_count", longint'(err_count8), exp_cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst8_in_ready", longint'(in_ready8), 0);
        check("rst8_busy", longint'(busy8), 0);
        check("rst8_res_valid", longint'(res_valid8), 0);
        check("rst8_err_count", longint'(err_count8), 0);
        check("rst8_err_max", longint'(err_max8), 0);
        check("rst8_err_sum", longint'(err_sum8), 0);
        check("rst2_in_ready", longint'(in_ready2), 0);

        // Short window with valid gaps; a mid-window start must be ignored
        q2.push_back('{3, 9, 14});
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        check("start2_in_ready", longint'(in_ready2), 1);
        for (int i = 0; i < 6; i++) begin
            in_valid2  = w2_v[i] != 0;
            in_a2      = w2_a[i];
            in_b2      = w2_b[i];
            in_approx2 = w2_ap[i];
            start2     = (i == 1);
            @(posedge clk); #1;
        end
        start2 = 1'b0;
        check("w2_in_ready_after_4th", longint'(in_ready2), 0);
        check("w2_busy_drain", longint'(busy2), 1);
        in_valid2  = 1'b1;
        in_a2      = 15'h7FFF;
        in_b2      = 15'h7FFF;
        in_approx2 = 16'd0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0;
        guard = 0;
        while (!res_valid2 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("w2_res_valid", longint'(res_valid2), 1);
        res_ack2 = 1'b1;
        @(posedge clk); #1;
        res_ack2 = 1'b0;
        check("w2_ack_res_valid", longint'(res_valid2), 0);
        check("w2_kept_sum", longint'(err_sum2), 14);

        // Constant error 255 on every sample
        q8.push_back('{256, 255, 65280});
        run8(0, 256);
        ack8(256);

        // Exact approximate sums
        q8.push_back('{0, 0, 0});
        run8(1, 0);
        ack8(0);

        // Worst-case distance
        q8.push_back('{256, 65534, 16776704});
        run8(2, 256);

        // start and res_ack together: start wins, accumulators clear
        start8   = 1'b1;
        res_ack8 = 1'b1;
        @(posedge clk); #1;
        start8   = 1'b0;
        res_ack8 = 1'b0;
        check("startack_res_valid", longint'(res_valid8), 0);
        check("startack_busy", longint'(busy8), 1);
        check("startack_in_ready", longint'(in_ready8), 1);
        check("startack_err_count", longint'(err_count8), 0);
        check("startack_err_max", longint'(err_max8), 0);
        check("startack_err_sum", longint'(err_sum8), 0);

        // Reset with two samples in flight
        send8(15'd1, 15'd2, 16'd0);
        send8(15'd3, 15'd4, 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", longint'(busy8), 0);
        check("midrst_in_ready", longint'(in_ready8), 0);
        check("midrst_res_valid", longint'(res_valid8), 0);
        check("midrst_err_count", longint'(err_count8), 0);
        check("midrst_err_max", longint'(err_max8), 0);
        check("midrst_err_sum", longint'(err_sum8), 0);
        in_valid8  = 1'b1;
        in_approx8 = 16'd500;
        repeat (4) begin
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        check("idle_in_ready", longint'(in_ready8), 0);
        check("idle_err_sum", longint'(err_sum8), 0);
        check("idle_err_count", longint'(err_count8), 0);

        repeat (2) @(posedge clk);
        #1;
        check("q8_drained", longint'(q8.size()), 0);
        check("q2_drained", longint'(q2.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
